// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR bank: word type, FSM encoding, byte-lane merge.
package csr_pkg;

    localparam int CSR_WORD_W = 32;

    typedef logic [CSR_WORD_W-1:0] csr_word_t;

    typedef enum logic [1:0] {IDLE, WR, RD_IDX, RD_OUT} csr_fsm_e;

    function automatic csr_word_t csr_byte_merge(input csr_word_t old_w,
                                                 input csr_word_t new_w,
                                                 input logic [3:0] we);
        csr_word_t r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (we[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/csr_read_mux.sv
// Combinational word-index decode for reads: control regs, status window, else a fixed value.
module csr_read_mux
    import csr_pkg::*;
#(
    parameter int        NUM_CTRL     = 512,
    parameter int        NUM_STAT     = 512,
    parameter int        IDX_W        = 11,
    parameter int        STAT_BASE    = 512,
    parameter csr_word_t UNMAPPED_VAL = '0
) (
    input  logic [IDX_W-1:0]                            i_idx,
    input  csr_word_t [NUM_CTRL-1:0]                    i_ctrl,
    input  csr_word_t [(NUM_STAT > 0 ? NUM_STAT : 1)-1:0] i_stat,
    output csr_word_t                                   o_data
);

    localparam int CW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam int SW = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;

    // Decode at 32 bits so every range check is a full-width compare with no aliasing.
    logic [31:0] w_idx32;
    logic [31:0] w_soff;

    assign w_idx32 = 32'(i_idx);
    assign w_soff  = w_idx32 - 32'(STAT_BASE);

    always_comb begin
        o_data = UNMAPPED_VAL;
        if (w_idx32 < 32'(NUM_CTRL)) begin
            o_data = i_ctrl[w_idx32[CW-1:0]];
        end else if ((NUM_STAT > 0) && (w_idx32 >= 32'(STAT_BASE)) &&
                     (w_soff < 32'(NUM_STAT))) begin
            o_data = i_stat[w_soff[SW-1:0]];
        end
    end

endmodule

// File: rtl/csr_bank.sv
// Host-facing control/status register bank on the BRAM-controller port, single user clock.
module csr_bank
    import csr_pkg::*;
#(
    parameter int                  NUM_CTRL      = 512,
    parameter int                  NUM_STAT      = 512,
    parameter int                  ADDR_W        = 13,
    parameter int                  STAT_BASE     = 512,
    parameter logic [NUM_CTRL-1:0] SELF_CLR_MASK = '0,
    parameter csr_word_t           UNMAPPED_VAL  = '0
) (
    input  logic                                        i_user_clk,
    input  logic                                        i_user_aresetn,
    input  logic                                        i_bram_en,
    input  logic [3:0]                                  i_bram_we,
    input  logic [ADDR_W-1:0]                           i_bram_addr,
    input  csr_word_t                                   i_bram_wrdata,
    output csr_word_t                                   o_bram_rddata,
    output logic                                        o_bram_rdvalid,
    output csr_word_t [NUM_CTRL-1:0]                    o_ctrl_reg,
    output logic [NUM_CTRL-1:0]                         o_ctrl_wr_pulse,
    input  csr_word_t [(NUM_STAT > 0 ? NUM_STAT : 1)-1:0] i_stat_reg,
    output logic [15:0]                                 o_drop_cnt
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CW    = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam int SN    = (NUM_STAT > 0) ? NUM_STAT : 1;

    csr_fsm_e                r_state, w_next;
    logic [IDX_W-1:0]        r_idx;
    csr_word_t               r_wdata;
    logic [3:0]              r_we;
    logic                    r_wr_go;
    csr_word_t [NUM_CTRL-1:0] r_ctrl;
    logic [NUM_CTRL-1:0]     r_pulse;
    csr_word_t [SN-1:0]      r_stat;
    csr_word_t               r_rddata;
    logic                    r_rdvalid;
    logic [15:0]             r_drop;
    csr_word_t               w_rd_word;
    logic                    w_accept;
    logic [1:0]              w_unused_addr_lsb;

    assign w_unused_addr_lsb = i_bram_addr[1:0];
    assign w_accept          = i_bram_en && (r_state == IDLE);

    always_ff @(posedge i_user_clk or negedge i_user_aresetn) begin
        if (!i_user_aresetn) r_state <= IDLE;
        else                 r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_bram_en) w_next = (|i_bram_we) ? WR : RD_IDX;
            WR:      w_next = IDLE;
            RD_IDX:  w_next = RD_OUT;
            RD_OUT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Writes commit one cycle after WR so the new value lands at request edge + 2.
    always_ff @(posedge i_user_clk or negedge i_user_aresetn) begin
        if (!i_user_aresetn) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_we    <= '0;
            r_wr_go <= 1'b0;
        end else begin
            r_wr_go <= (r_state == WR) && (32'(r_idx) < 32'(NUM_CTRL));
            if (w_accept) begin
                r_idx   <= i_bram_addr[ADDR_W-1:2];
                r_wdata <= i_bram_wrdata;
                r_we    <= i_bram_we;
            end
        end
    end

    always_ff @(posedge i_user_clk or negedge i_user_aresetn) begin
        if (!i_user_aresetn) begin
            r_ctrl  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            if (r_wr_go) r_pulse[r_idx[CW-1:0]] <= 1'b1;
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (r_wr_go && (r_idx[CW-1:0] == CW'(i)))
                    r_ctrl[i] <= csr_byte_merge(r_ctrl[i], r_wdata, r_we);
                else if (SELF_CLR_MASK[i] && r_pulse[i])
                    r_ctrl[i] <= '0;
            end
        end
    end

    csr_read_mux #(
        .NUM_CTRL     (NUM_CTRL),
        .NUM_STAT     (NUM_STAT),
        .IDX_W        (IDX_W),
        .STAT_BASE    (STAT_BASE),
        .UNMAPPED_VAL (UNMAPPED_VAL)
    ) u_rd_mux (
        .i_idx  (r_idx),
        .i_ctrl (r_ctrl),
        .i_stat (r_stat),
        .o_data (w_rd_word)
    );

    always_ff @(posedge i_user_clk or negedge i_user_aresetn) begin
        if (!i_user_aresetn) begin
            r_stat    <= '0;
            r_rddata  <= '0;
            r_rdvalid <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_stat    <= i_stat_reg;
            r_rdvalid <= (r_state == RD_OUT);
            if (r_state == RD_OUT) r_rddata <= w_rd_word;
            if (i_bram_en && (r_state != IDLE) && (r_drop != 16'hFFFF))
                r_drop <= r_drop + 16'd1;
        end
    end

    assign o_bram_rddata   = r_rddata;
    assign o_bram_rdvalid  = r_rdvalid;
    assign o_ctrl_reg      = r_ctrl;
    assign o_ctrl_wr_pulse = r_pulse;
    assign o_drop_cnt      = r_drop;

endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: directed vector table, drop/reset sequences, then random ops vs a register model.
module tb_csr_bank;

    localparam int          NC  = 512;
    localparam int          NS  = 512;
    localparam int          SB  = 512;
    localparam int          AW  = 13;
    localparam logic [31:0] UNM = 32'hBAD0_BAD0;
    localparam logic [NC-1:0] MASK = {{(NC-1){1'b0}}, 1'b1} << 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic [3:0]             we = '0;
    logic [AW-1:0]          addr = '0;
    logic [31:0]            wdata = '0;
    logic [31:0]            rddata;
    logic                   rdvalid;
    logic [NC-1:0][31:0]    ctrl;
    logic [NC-1:0]          pulse;
    logic [NS-1:0][31:0]    stat = '0;
    logic [15:0]            drop;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_ctrl [NC];

    always #5 clk = ~clk;

    csr_bank #(
        .NUM_CTRL(NC), .NUM_STAT(NS), .ADDR_W(AW), .STAT_BASE(SB),
        .SELF_CLR_MASK(MASK), .UNMAPPED_VAL(UNM)
    ) dut (
        .i_user_clk(clk), .i_user_aresetn(rst_n), .i_bram_en(en), .i_bram_we(we),
        .i_bram_addr(addr), .i_bram_wrdata(wdata), .o_bram_rddata(rddata),
        .o_bram_rdvalid(rdvalid), .o_ctrl_reg(ctrl), .o_ctrl_wr_pulse(pulse),
        .i_stat_reg(stat), .o_drop_cnt(drop)
    );

    typedef struct {
        bit          wr;
        int          idx;
        logic [31:0] data;
        logic [3:0]  we;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model read value, from the address map rules.
    function automatic logic [31:0] model_rd(input int idx);
        if (idx < NC)                  return MASK[idx] ? 32'h0 : m_ctrl[idx];
        if (idx >= SB && idx < SB + NS) return stat[idx - SB];
        return UNM;
    endfunction

    task automatic chk_ctrl_vec(input string name);
        int nm = 0;
        for (int i = 0; i < NC; i++) if (ctrl[i] !== m_ctrl[i]) nm++;
        chk(name, 32'(nm), 32'd0);
    endtask

    task automatic drive(input int idx, input logic [3:0] w, input logic [31:0] d);
        en    = 1'b1;
        we    = w;
        wdata = d;
        addr  = {idx[AW-3:0], 2'($urandom_range(0, 3))};
    endtask

    task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] w,
                            input bit use_exp, input logic [31:0] exp);
        logic [31:0] bm;
        logic [NC-1:0] ep;
        bm = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        ep = '0;
        @(negedge clk); drive(idx, w, d);
        @(negedge clk); en = 1'b0;
        chk("wr_pulse_early", 32'(|pulse), 32'd0);
        @(negedge clk);
        chk_ctrl_vec("wr_not_yet");
        @(negedge clk);
        if (idx < NC) begin
            m_ctrl[idx] = (m_ctrl[idx] & ~bm) | (d & bm);
            ep[idx] = 1'b1;
            chk("wr_value", ctrl[idx], use_exp ? exp : m_ctrl[idx]);
        end
        chk("wr_pulse_cnt", 32'($countones(pulse)), 32'($countones(ep)));
        chk("wr_pulse_vec", 32'(pulse == ep), 32'd1);
        chk_ctrl_vec("wr_ctrl_vec");
        @(negedge clk);
        if (idx < NC && MASK[idx]) m_ctrl[idx] = 32'h0;
        chk("wr_pulse_off", 32'(|pulse), 32'd0);
        chk_ctrl_vec("wr_after");
    endtask

    task automatic do_read(input int idx, input logic [31:0] exp);
        @(negedge clk); drive(idx, 4'b0000, $urandom);
        @(negedge clk); en = 1'b0;
        chk("rd_valid_t1", 32'(rdvalid), 32'd0);
        @(negedge clk);
        chk("rd_valid_t2", 32'(rdvalid), 32'd0);
        @(negedge clk);
        chk("rd_valid", 32'(rdvalid), 32'd1);
        chk("rd_data", rddata, exp);
        @(negedge clk);
        chk("rd_valid_off", 32'(rdvalid), 32'd0);
        chk("rd_hold", rddata, exp);
    endtask

    function automatic vec_t mk(input bit wr, input int idx, input logic [31:0] d,
                                input logic [3:0] w, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.idx = idx; v.data = d; v.we = w; v.exp = exp;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < NC; i++) m_ctrl[i] = 32'h0;
        stat[0]   = 32'hA5A5_0001;
        stat[511] = 32'h5A5A_01FF;

        tbl.push_back(mk(0, 0,    0, 0, 32'h0));
        tbl.push_back(mk(0, 511,  0, 0, 32'h0));
        tbl.push_back(mk(0, 512,  0, 0, 32'hA5A5_0001));
        tbl.push_back(mk(0, 1023, 0, 0, 32'h5A5A_01FF));
        tbl.push_back(mk(0, 1024, 0, 0, UNM));
        tbl.push_back(mk(0, 2047, 0, 0, UNM));
        tbl.push_back(mk(1, 3, 32'hFFFF_FFFF, 4'b1111, 32'hFFFF_FFFF));
        tbl.push_back(mk(1, 3, 32'h1122_3344, 4'b0101, 32'hFF22_FF44));
        tbl.push_back(mk(0, 3, 0, 0, 32'hFF22_FF44));
        tbl.push_back(mk(1, 511, 32'hCAFE_F00D, 4'b1000, 32'hCA00_0000));
        tbl.push_back(mk(0, 511, 0, 0, 32'hCA00_0000));
        tbl.push_back(mk(1, 5, 32'h0000_0001, 4'b1111, 32'h0000_0001));
        tbl.push_back(mk(0, 5, 0, 0, 32'h0));
        tbl.push_back(mk(1, 512, 32'hDEAD_BEEF, 4'b1111, 32'h0));
        tbl.push_back(mk(0, 512, 0, 0, 32'hA5A5_0001));
        tbl.push_back(mk(1, 1500, 32'h1234_5678, 4'b1111, 32'h0));
        tbl.push_back(mk(0, 1500, 0, 0, UNM));
        tbl.push_back(mk(1, 0, 32'h0000_00AB, 4'b0001, 32'h0000_00AB));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0000_00AB));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rddata", rddata, 32'h0);
        chk("rst_rdvalid", 32'(rdvalid), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_pulse", 32'(|pulse), 32'd0);
        chk_ctrl_vec("rst_ctrl");

        foreach (tbl[k]) begin
            if (tbl[k].wr) do_write(tbl[k].idx, tbl[k].data, tbl[k].we, 1'b1, tbl[k].exp);
            else           do_read(tbl[k].idx, tbl[k].exp);
        end

        // Back-to-back requests while busy: only the first read is serviced.
        @(negedge clk); drive(512, 4'b0000, 0);
        @(negedge clk); drive(3, 4'b0000, 0);
        chk("drop_rv1", 32'(rdvalid), 32'd0);
        @(negedge clk); drive(1024, 4'b0000, 0);
        chk("drop_rv2", 32'(rdvalid), 32'd0);
        chk("drop_cnt1", 32'(drop), 32'd1);
        @(negedge clk); en = 1'b0;
        chk("drop_rv3", 32'(rdvalid), 32'd1);
        chk("drop_data", rddata, 32'hA5A5_0001);
        chk("drop_cnt2", 32'(drop), 32'd2);
        @(negedge clk);
        chk("drop_rv4", 32'(rdvalid), 32'd0);
        @(negedge clk);
        chk("drop_rv5", 32'(rdvalid), 32'd0);
        chk("drop_hold", 32'(drop), 32'd2);

        for (int n = 0; n < 60; n++) begin
            int idx;
            int sel;
            logic [31:0] d;
            logic [3:0]  w;
            for (int j = 0; j < NS; j += 37) stat[j] = $urandom;
            stat[0]   = $urandom;
            stat[511] = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       idx = $urandom_range(0, NC - 1);
                1:       idx = $urandom_range(SB, SB + NS - 1);
                2:       idx = $urandom_range(SB + NS, 2047);
                default: begin
                    int b;
                    b = $urandom_range(0, 6);
                    idx = (b == 0) ? 0 : (b == 1) ? 511 : (b == 2) ? 512 :
                          (b == 3) ? 1023 : (b == 4) ? 1024 : (b == 5) ? 2047 : 5;
                end
            endcase
            d = $urandom;
            w = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) do_write(idx, d, w, 1'b0, 32'h0);
            else                           do_read(idx, model_rd(idx));
        end
        chk("rand_drop", 32'(drop), 32'd2);

        // Reset asserted while the read sits in RD_IDX.
        m_ctrl[7] = m_ctrl[7];
        do_write(3, 32'h0BAD_F00D, 4'b1111, 1'b1, 32'h0BAD_F00D);
        @(negedge clk); drive(3, 4'b0000, 0);
        @(negedge clk); en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) m_ctrl[i] = 32'h0;
        chk("mrst_rdvalid", 32'(rdvalid), 32'd0);
        chk("mrst_rddata", rddata, 32'h0);
        chk("mrst_drop", 32'(drop), 32'd0);
        chk("mrst_pulse", 32'(|pulse), 32'd0);
        chk_ctrl_vec("mrst_ctrl");
        repeat (2) begin
            @(negedge clk);
            chk("mrst_rv_hold", 32'(rdvalid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rv_rel", 32'(rdvalid), 32'd0);
        @(negedge clk);
        chk("mrst_rv_rel2", 32'(rdvalid), 32'd0);
        do_read(512, stat[0]);
        do_read(3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
